proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
Run controller sitting between the top-level clock/reset and the processor core(s). It replaces hard-coded reset timing and fixed run length with a parametrised sequence: reset stretching, a gated run window, halt detection across NUM_CORES cores, and a cycle-count timeout. It exposes the cycle count and completion status so benches and on-chip status logic can judge a program run.

Parameters:
RST_CYCLES, 2, cycles core_rst_n is held low after start is accepted (>=1)
MAX_CYCLES, 20, run-window timeout in RUN cycles (>=1)
NUM_CORES, 1, number of core halt inputs monitored
CNT_W, 32, cycle_count width; must satisfy 2^CNT_W > MAX_CYCLES

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new run; sampled in IDLE and DONE only
core_halt  in  NUM_CORES  per-core halt indication (ebreak/ecall/end of program), level
core_rst_n  out  1  synchronous active-low reset to the core(s)
core_en  out  1  run enable to the core(s)
cycle_count  out  CNT_W  RUN cycles elapsed in the current/last run
halted_mask  out  NUM_CORES  sticky record of cores that have halted
done  out  1  run finished (halt or timeout); level, held in DONE
timeout  out  1  run ended by MAX_CYCLES, not by halt
state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE, core_rst_n=0, core_en=0, cycle_count=0, halted_mask=0, done=0, timeout=0. Takes effect immediately, including mid-RUN. Release is synchronous to the next rising edge.
- States: IDLE=0, RESET=1, RUN=2, DONE=3. All outputs are registered.
- IDLE: core_rst_n=0, core_en=0. start=1 -> RESET. Reset-stretch counter loads RST_CYCLES-1.
- RESET: core_rst_n=0, core_en=0. Counter decrements each cycle. At 0 -> RUN. core_rst_n is low for exactly RST_CYCLES cycles counted from the edge that leaves IDLE/DONE.
  - Entering RESET clears cycle_count, halted_mask, done and timeout.
  - start is ignored in RESET.
- RUN: core_rst_n=1, core_en=1.
  - Every rising edge in RUN, including the exiting edge, does cycle_count += 1. cycle_count saturates at all-ones.
  - halted_mask <= halted_mask | core_halt.
  - all_halt = &(halted_mask | core_halt).
  - If all_halt: -> DONE, done=1, timeout=0.
  - Else if cycle_count == MAX_CYCLES-1: -> DONE, done=1, timeout=1. cycle_count ends at MAX_CYCLES.
  - Simultaneous halt completion and timeout: halt wins, timeout=0.
  - start is ignored in RUN.
- DONE: core_en=0, core_rst_n=1 (core state preserved for inspection). cycle_count, halted_mask and timeout are frozen; done=1.
  - start=1 -> RESET, restarting the sequence.
  - core_halt is ignored.
- core_halt is ignored outside RUN. A halt asserted during the first RUN cycle counts, giving cycle_count=1.
- With NUM_CORES=1, halted_mask is a single sticky bit.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RESET, ST_RUN, ST_DONE) and the 2-bit state width, reused by the top-level and benches.
- Optional sub-module rst_stretch holds the RST_CYCLES down-counter. Its interface is load, busy and cnt.
- Everything else stays in one FSM module.

Test Plan:
- Defaults, start pulse, core_halt=0 -> core_rst_n low 2 cycles, core_en high 20 cycles, then done=1, timeout=1, cycle_count=20, state=3.
- Defaults, core_halt=1 during the 5th RUN cycle -> next edge done=1, timeout=0, cycle_count=5, halted_mask=1, core_en=0.
- NUM_CORES=2: core0 halt pulse in RUN cycle 3, core1 halt in cycle 7 -> halted_mask=01 after cycle 3, done after cycle 7, cycle_count=7, timeout=0.
- Defaults, halt asserted exactly in the 20th RUN cycle -> done=1, timeout=0, cycle_count=20.
- rst_n pulsed low mid-RUN (cycle 8) -> core_rst_n=0, core_en=0, cycle_count=0, state=0 immediately. A start pulse while in RUN has no effect.
- From DONE (timeout run), start pulse -> RESET clears done, timeout and cycle_count. A second run halting at cycle 4 ends with cycle_count=4.

Source files
------------

// File: rtl/proc_run_ctrl_pkg.sv
// Shared definitions for the processor run controller: state encoding and
// width helpers used by the RTL and the bench.
`default_nettype none

package proc_run_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter width able to hold depth-1, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_run_ctrl_rst_stretch.sv
// Reset-stretch down-counter: load arms it at RST_CYCLES-1, busy stays high
// until the edge on which the count has reached zero.
`default_nettype none

module proc_run_ctrl_rst_stretch
    import proc_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CW         = cnt_width(RST_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    output logic          busy,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = CW'(RST_CYCLES - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign cnt  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/proc_run_ctrl.sv
// Run controller for the processor core(s): stretched core reset, gated run
// window, multi-core halt detection and cycle-count timeout.
`default_nettype none

module proc_run_ctrl
    import proc_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 20,
    parameter int NUM_CORES  = 1,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_halt,
    output logic                 core_rst_n,
    output logic                 core_en,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic                 done,
    output logic                 timeout,
    output logic [STATE_W-1:0]   state
);

    localparam int SCW = cnt_width(RST_CYCLES);

    state_t               state_q, state_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 core_en_q, core_en_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [NUM_CORES-1:0] halted_mask_q, halted_mask_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;

    logic                 stretch_load;
    logic                 stretch_busy;
    logic [SCW-1:0]       stretch_cnt;
    logic                 all_halt;

    proc_run_ctrl_rst_stretch #(
        .RST_CYCLES (RST_CYCLES),
        .CW         (SCW)
    ) u_rst_stretch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (stretch_load),
        .busy  (stretch_busy),
        .cnt   (stretch_cnt)
    );

    // Halts seen this cycle count toward completion, so a core halting in
    // the same cycle as the timeout still ends the run cleanly.
    assign all_halt = &(halted_mask_q | core_halt);

    always_comb begin
        state_d       = state_q;
        core_rst_n_d  = core_rst_n_q;
        core_en_d     = core_en_q;
        cycle_count_d = cycle_count_q;
        halted_mask_d = halted_mask_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        stretch_load  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_RESET;
                    stretch_load  = 1'b1;
                    core_rst_n_d  = 1'b0;
                    core_en_d     = 1'b0;
                    cycle_count_d = '0;
                    halted_mask_d = '0;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            ST_RESET: begin
                if (stretch_busy && (stretch_cnt == '0)) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                    core_en_d    = 1'b1;
                end
            end
            ST_RUN: begin
                cycle_count_d = (cycle_count_q == '1) ? cycle_count_q
                                                      : cycle_count_q + CNT_W'(1);
                halted_mask_d = halted_mask_q | core_halt;
                if (all_halt) begin
                    state_d   = ST_DONE;
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            core_rst_n_q  <= 1'b0;
            core_en_q     <= 1'b0;
            cycle_count_q <= '0;
            halted_mask_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_rst_n_q  <= core_rst_n_d;
            core_en_q     <= core_en_d;
            cycle_count_q <= cycle_count_d;
            halted_mask_q <= halted_mask_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign core_en     = core_en_q;
    assign cycle_count = cycle_count_q;
    assign halted_mask = halted_mask_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed and randomized runs, each judged against
// a run-level model derived from per-cycle halt schedules.
`default_nettype none

module tb_proc_run_ctrl;
    import proc_run_ctrl_pkg::*;

    localparam int RSTC = 2;
    localparam int MAXC = 20;
    localparam int NC   = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NC-1:0] core_halt;
    logic          core_rst_n;
    logic          core_en;
    logic [CW-1:0] cycle_count;
    logic [NC-1:0] halted_mask;
    logic          done;
    logic          timeout;
    logic [1:0]    state;

    int n_vec = 0;
    int n_err = 0;

    // Halt vector driven during RUN cycle j (1-based).
    logic [NC-1:0] sched [1:MAXC];

    always #5 clk = ~clk;

    proc_run_ctrl #(
        .RST_CYCLES (RSTC),
        .MAX_CYCLES (MAXC),
        .NUM_CORES  (NC),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_halt   (core_halt),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .cycle_count (cycle_count),
        .halted_mask (halted_mask),
        .done        (done),
        .timeout     (timeout),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string ph, input int st, input int rn, input int en,
                              input int cnt, input int mask, input int dn, input int to);
        chk({ph, ".state"},       32'(state),       32'(st));
        chk({ph, ".core_rst_n"},  32'(core_rst_n),  32'(rn));
        chk({ph, ".core_en"},     32'(core_en),     32'(en));
        chk({ph, ".cycle_count"}, 32'(cycle_count), 32'(cnt));
        chk({ph, ".halted_mask"}, 32'(halted_mask), 32'(mask));
        chk({ph, ".done"},        32'(done),        32'(dn));
        chk({ph, ".timeout"},     32'(timeout),     32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int j = 1; j <= MAXC; j++) sched[j] = '0;
    endtask

    task automatic set_pulse(input int core, input int cyc);
        if (cyc >= 1 && cyc <= MAXC) sched[cyc][core] = 1'b1;
    endtask

    task automatic set_level(input int core, input int from);
        for (int j = 1; j <= MAXC; j++)
            if (j >= from) sched[j][core] = 1'b1;
    endtask

    // One complete run from IDLE or DONE. abort_at>0 pulses rst_n low during
    // that RUN cycle and checks the asynchronous return to IDLE.
    task automatic do_run(input int abort_at);
        int            len;
        int            to;
        logic [NC-1:0] acc;
        logic [NC-1:0] exp_mask;

        acc = '0;
        len = MAXC;
        to  = 1;
        for (int j = 1; j <= MAXC; j++) begin
            acc = acc | sched[j];
            if (acc == {NC{1'b1}}) begin
                len = j;
                to  = 0;
                break;
            end
        end

        start     = 1'b1;
        core_halt = NC'($urandom);
        for (int k = 1; k <= RSTC; k++) begin
            step();
            check_outs("reset", int'(ST_RESET), 0, 0, 0, 0, 0, 0);
            start     = 1'($urandom_range(0, 1));
            core_halt = NC'($urandom);
        end

        exp_mask = '0;
        for (int j = 1; j <= len; j++) begin
            step();
            check_outs("run", int'(ST_RUN), 1, 1, j - 1, int'(exp_mask), 0, 0);
            if (abort_at == j) begin
                #2 rst_n = 1'b0;
                #1 check_outs("async_rst", int'(ST_IDLE), 0, 0, 0, 0, 0, 0);
                step();
                check_outs("rst_hold", int'(ST_IDLE), 0, 0, 0, 0, 0, 0);
                rst_n = 1'b1;
                start = 1'b0;
                step();
                check_outs("post_rst", int'(ST_IDLE), 0, 0, 0, 0, 0, 0);
                return;
            end
            core_halt = sched[j];
            start     = 1'($urandom_range(0, 1));
            exp_mask  = exp_mask | sched[j];
        end

        step();
        start = 1'b0;
        check_outs("done", int'(ST_DONE), 1, 0, len, int'(exp_mask), 1, to);
        repeat (3) begin
            core_halt = NC'($urandom);
            step();
            check_outs("frozen", int'(ST_DONE), 1, 0, len, int'(exp_mask), 1, to);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        core_halt = '0;
        repeat (2) @(posedge clk);
        #1 check_outs("por", int'(ST_IDLE), 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_outs("idle", int'(ST_IDLE), 0, 0, 0, 0, 0, 0);

        // timeout run, no halts
        clear_sched();
        do_run(0);
        // both cores halt (level) in RUN cycle 5
        clear_sched();
        set_level(0, 5); set_level(1, 5);
        do_run(0);
        // core0 pulse in cycle 3, core1 in cycle 7
        clear_sched();
        set_pulse(0, 3); set_level(1, 7);
        do_run(0);
        // halt exactly in the last RUN cycle beats the timeout
        clear_sched();
        set_pulse(0, MAXC); set_pulse(1, MAXC);
        do_run(0);
        // timeout run, then restart from DONE halting in cycle 4
        clear_sched();
        do_run(0);
        set_level(0, 4); set_level(1, 4);
        do_run(0);
        // asynchronous reset in RUN cycle 8
        clear_sched();
        do_run(8);

        for (int r = 0; r < 40; r++) begin
            clear_sched();
            for (int c = 0; c < NC; c++) begin
                case ($urandom_range(0, 3))
                    0:       ;
                    1:       set_pulse(c, int'($urandom_range(1, MAXC + 3)));
                    2:       set_level(c, int'($urandom_range(1, MAXC + 3)));
                    default: begin
                        set_pulse(c, int'($urandom_range(1, MAXC)));
                        set_pulse(c, int'($urandom_range(1, MAXC)));
                    end
                endcase
            end
            do_run((r % 10 == 9) ? int'($urandom_range(1, 6)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
